// File: rtl/sar_search.sv
// sar_search: successive-approximation engine driving operand A of an external
// magnitude comparator to locate a hidden B value in 0 .. 2^WIDTH-1.
// Optional build macro SAR_ERRCHK_EN: abort the search (err=1) on any comparator
// code that is not exactly one-hot. Without it the code is resolved eq > gt > lt.
module sar_search #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            A_gt_B,
    input  logic                            A_eq_B,
    input  logic                            A_lt_B,
    output logic [WIDTH-1:0]                guess,
    output logic                            busy,
    output logic                            done,
    output logic                            found,
    output logic [WIDTH-1:0]                result,
    output logic [$clog2(WIDTH+2)-1:0]      steps,
    output logic                            err
);

    localparam int unsigned LW   = WIDTH + 1;            // bound width, no wrap at the range edges
    localparam int unsigned SUMW = LW + 1;               // width of lo+hi
    localparam int unsigned SW   = $clog2(WIDTH + 2);    // probe counter width
    localparam logic [WIDTH-1:0] TOP   = '1;
    localparam logic [WIDTH-1:0] FIRST = TOP >> 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state;
    logic [LW-1:0]   lo;
    logic [LW-1:0]   hi;
    logic [LW-1:0]   nlo;
    logic [LW-1:0]   nhi;
    logic [SUMW-1:0] sum;
    logic [WIDTH-1:0] nmid;
    logic            exhausted;
`ifdef SAR_ERRCHK_EN
    logic            bad_code;
`endif

    // Narrowed bounds and next probe for the comparator answer to the current guess
    always_comb begin
        nlo       = lo;
        nhi       = hi;
        exhausted = 1'b0;
`ifdef SAR_ERRCHK_EN
        bad_code  = !({A_gt_B, A_eq_B, A_lt_B} == 3'b100 ||
                      {A_gt_B, A_eq_B, A_lt_B} == 3'b010 ||
                      {A_gt_B, A_eq_B, A_lt_B} == 3'b001);
`endif
        if (A_eq_B) begin
            nlo = lo;
        end else if (A_gt_B) begin
            nhi = LW'(guess) - LW'(1);
        end else if (A_lt_B || !A_gt_B) begin
            // lt, or an all-zero code, moves the lower bound up
            nlo = LW'(guess) + LW'(1);
        end
        // guess-1 at 0 would underflow the unsigned bound, so it is caught directly
        exhausted = (!A_eq_B && A_gt_B && guess == '0) || (nlo > nhi);
        sum       = SUMW'(nlo) + SUMW'(nhi);
        nmid      = WIDTH'(sum >> 1);
    end

    // Search FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            lo     <= '0;
            hi     <= '0;
            guess  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            result <= '0;
            steps  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lo    <= '0;
                        hi    <= LW'(TOP);
                        guess <= FIRST;
                        steps <= '0;
                        found <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    steps <= steps + SW'(1);
`ifdef SAR_ERRCHK_EN
                    if (bad_code) begin
                        err   <= 1'b1;
                        found <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else
`endif
                    if (A_eq_B) begin
                        result <= guess;
                        found  <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (exhausted) begin
                        found <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        lo    <= nlo;
                        hi    <= nhi;
                        guess <= nmid;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed scoreboard bench for sar_search (WIDTH=4).
// Honors SAR_ERRCHK_EN the same way as the design build.
module tb_sar_search;

    localparam int W  = 4;
    localparam int SW = $clog2(W + 2);
    localparam int MAXV = (1 << W) - 1;

    // comparator behaviours
    localparam int M_NORMAL  = 0;
    localparam int M_ALWAYSLT = 1;
    localparam int M_GTLT    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          A_gt_B, A_eq_B, A_lt_B;
    logic [W-1:0]  guess;
    logic          busy, done, found, err;
    logic [W-1:0]  result;
    logic [SW-1:0] steps;

    int target = 0;
    int mode   = M_NORMAL;

    int vectors = 0;
    int miscompares = 0;
    int last_result = 0;

    typedef struct {
        int found;
        int result;
        int steps;
        int err;
    } exp_t;

    int   gq[$];
    exp_t fq[$];

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A_gt_B (A_gt_B),
        .A_eq_B (A_eq_B),
        .A_lt_B (A_lt_B),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .result (result),
        .steps  (steps),
        .err    (err)
    );

    always #5 clk = ~clk;

    // comparator answer {gt, eq, lt} for a probe value
    function automatic logic [2:0] answer(input int md, input int g, input int t);
        case (md)
            M_ALWAYSLT: answer = 3'b001;
            M_GTLT:     answer = 3'b101;
            default:    answer = {g > t, g == t, g < t};
        endcase
    endfunction

    // external comparator
    always_comb begin
        {A_gt_B, A_eq_B, A_lt_B} = answer(mode, int'(guess), target);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // push expected probe sequence and final outcome for one search
    task automatic predict(input int tgt, input int md);
        int lo, hi, g, st;
        logic [2:0] a;
        exp_t e;
        lo = 0; hi = MAXV; st = 0;
        e.found = 0; e.err = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            g = (lo + hi) / 2;
            gq.push_back(g);
            st++;
            a = answer(md, g, tgt);
`ifdef SAR_ERRCHK_EN
            if (a != 3'b100 && a != 3'b010 && a != 3'b001) begin
                e.err = 1;
                break;
            end
`endif
            if (a[1]) begin
                e.found = 1;
                last_result = g;
                break;
            end else if (a[2]) begin
                hi = g - 1;
            end else begin
                lo = g + 1;
            end
            if (lo > hi) break;
        end
        e.steps  = st;
        e.result = last_result;
        fq.push_back(e);
    endtask

    // run one search; pulse start again at probe index 'extra_start' (-1 = never)
    task automatic run_search(input int tgt, input int md, input int extra_start, input string tag);
        int n;
        int eg;
        exp_t e;
        predict(tgt, md);
        @(negedge clk);
        target = tgt;
        mode   = md;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 12) begin
            start = (n == extra_start);
            if (gq.size() > 0) begin
                eg = gq.pop_front();
                chk({tag, "_guess"}, 32'(guess), 32'(eg));
            end else begin
                chk({tag, "_extra_probe"}, 32'(n), 32'(-1));
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_probes_left"}, 32'(gq.size()), 32'd0);
        gq.delete();
        e = fq.pop_front();
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_found"}, 32'(found), 32'(e.found));
        chk({tag, "_result"}, 32'(result), 32'(e.result));
        chk({tag, "_steps"}, 32'(steps), 32'(e.steps));
        chk({tag, "_steps_max"}, 32'(steps <= SW'(W + 1)), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'(e.err));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_guess"},  32'(guess),  32'd0);
        chk({tag, "_busy"},   32'(busy),   32'd0);
        chk({tag, "_done"},   32'(done),   32'd0);
        chk({tag, "_found"},  32'(found),  32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_steps"},  32'(steps),  32'd0);
        chk({tag, "_err"},    32'(err),    32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        // corner targets
        run_search(15, M_NORMAL, -1, "t15");
        run_search(0, M_NORMAL, -1, "t0");

        // every target
        for (int t = 0; t <= MAXV; t++) begin
            run_search(t, M_NORMAL, -1, $sformatf("ex%0d", t));
        end

        // target never reached from below: bound must not wrap
        run_search(0, M_ALWAYSLT, -1, "always_lt");

        // illegal gt+lt code
        run_search(0, M_GTLT, -1, "gtlt");

        // start pulsed while busy is ignored
        run_search(9, M_NORMAL, 1, "restart_busy");

        // reset during the third probe
        @(negedge clk);
        target = 15;
        mode   = M_NORMAL;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_probe3", 32'(guess), 32'd13);
        #2 rst = 1'b1;
        #1 chk_zero("midrst_async");
        @(negedge clk);
        chk("midrst_hold_done", 32'(done), 32'd0);
        rst = 1'b0;
        last_result = 0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done), 32'd0);
            chk("midrst_idle", 32'(busy), 32'd0);
        end

        // recovers after reset
        run_search(5, M_NORMAL, -1, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
